// File: rtl/bin_to_bcd_display.sv
// Signed binary to per-digit seven_seg codes via iterative double-dabble,
// with sign placement, optional leading-zero blanking and overflow dashes.
module bin_to_bcd_display #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [DIGITS*5-1:0]   dig_value,
  output logic [DIGITS-1:0]     dig_en
);

  localparam logic [4:0] BCD_BLANK = 5'd16;
  localparam logic [4:0] BCD_NEG   = 5'd17;
  localparam int         BCD_W     = 4 * (DIGITS + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, FORMAT} state_t;

  state_t                state, state_next;
  logic [4:0]            cnt;
  logic                  neg;
  logic                  blz;
  logic [WIDTH-1:0]      mag;
  logic [BCD_W-1:0]      bcd;
  logic [BCD_W-1:0]      bcd_adj;
  logic                  fmt_ovf;
  logic [DIGITS*5-1:0]   fmt_value;
  logic [DIGITS-1:0]     fmt_en;
  int                    msd;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = CONVERT;
      CONVERT: if (cnt == 5'(WIDTH - 1)) state_next = FORMAT;
      FORMAT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i <= DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // A negative result needs one spare digit for the minus sign.
  always_comb begin
    fmt_value = '0;
    fmt_en    = '0;
    msd       = 0;
    fmt_ovf   = (bcd[4*DIGITS +: 4] != 4'd0) ||
                (neg && (bcd[4*(DIGITS-1) +: 4] != 4'd0));
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = i;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (fmt_ovf) begin
        fmt_value[5*i +: 5] = BCD_NEG;
        fmt_en[i]           = 1'b1;
      end else if (blz && (i > msd)) begin
        if (neg && (i == msd + 1)) begin
          fmt_value[5*i +: 5] = BCD_NEG;
          fmt_en[i]           = 1'b1;
        end else begin
          fmt_value[5*i +: 5] = BCD_BLANK;
          fmt_en[i]           = 1'b0;
        end
      end else if (!blz && neg && (i == DIGITS - 1)) begin
        fmt_value[5*i +: 5] = BCD_NEG;
        fmt_en[i]           = 1'b1;
      end else begin
        fmt_value[5*i +: 5] = {1'b0, bcd[4*i +: 4]};
        fmt_en[i]           = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done      <= 1'b0;
      ovf       <= 1'b0;
      dig_en    <= '0;
      dig_value <= {DIGITS{BCD_BLANK}};
      cnt       <= '0;
      neg       <= 1'b0;
      blz       <= 1'b0;
      mag       <= '0;
      bcd       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            neg <= value[WIDTH-1];
            mag <= value[WIDTH-1] ? -value : value;
            blz <= blank_lz;
            bcd <= '0;
            cnt <= '0;
          end
        end
        CONVERT: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          cnt        <= cnt + 5'd1;
        end
        FORMAT: begin
          done      <= 1'b1;
          ovf       <= fmt_ovf;
          dig_value <= fmt_value;
          dig_en    <= fmt_en;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Scoreboard bench for bin_to_bcd_display: arithmetic reference model, latency,
// load-while-busy, back-to-back and reset-abort scenarios.
module tb_bin_to_bcd_display;

  localparam int         WIDTH     = 14;
  localparam int         DIGITS    = 4;
  localparam logic [4:0] BCD_BLANK = 5'd16;
  localparam logic [4:0] BCD_NEG   = 5'd17;
  localparam int         LATENCY   = WIDTH + 2;

  typedef struct {
    logic [DIGITS*5-1:0] dv;
    logic [DIGITS-1:0]   en;
    logic                ovf;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                load = 1'b0;
  logic [WIDTH-1:0]    value = '0;
  logic                blank_lz = 1'b0;
  logic                busy;
  logic                done;
  logic                ovf;
  logic [DIGITS*5-1:0] dig_value;
  logic [DIGITS-1:0]   dig_en;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  int vals[10] = '{1234, 42, 42, -42, -42, 0, -999, -1000, -8192, 8191};
  bit blzs[10] = '{1,    1,  0,  1,   0,   1, 1,    1,     0,     0};

  bin_to_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_lz(blank_lz),
    .busy(busy), .done(done), .ovf(ovf), .dig_value(dig_value), .dig_en(dig_en)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(int v, bit blz);
    exp_t e;
    int   mag = (v < 0) ? -v : v;
    bit   neg = (v < 0);
    int   d[DIGITS];
    int   p = 1;
    int   msd = 0;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = (mag / p) % 10;
      p = p * 10;
      if (d[i] != 0) msd = i;
    end
    e.ovf = neg ? (mag >= p / 10) : (mag >= p);
    for (int i = 0; i < DIGITS; i++) begin
      if (e.ovf) begin
        e.dv[5*i +: 5] = BCD_NEG; e.en[i] = 1'b1;
      end else if (blz && i > msd) begin
        e.dv[5*i +: 5] = (neg && i == msd + 1) ? BCD_NEG : BCD_BLANK;
        e.en[i]        = (neg && i == msd + 1);
      end else if (!blz && neg && i == DIGITS - 1) begin
        e.dv[5*i +: 5] = BCD_NEG; e.en[i] = 1'b1;
      end else begin
        e.dv[5*i +: 5] = 5'(d[i]); e.en[i] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    n_checks++; if (dig_en !== '0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", dig_en); end
    n_checks++;
    if (dig_value !== {DIGITS{BCD_BLANK}}) begin
      n_fail++; $display("FAIL reset_value: got %h expected %h", dig_value, {DIGITS{BCD_BLANK}});
    end
  endtask

  task automatic test_conversions();
    for (int t = 0; t < 10; t++) begin : conv
      int   lat;
      bit   busy_ok;
      exp_t x;
      @(negedge clk);
      value = WIDTH'(vals[t]); blank_lz = blzs[t]; load = 1'b1;
      sb.push_back(model(vals[t], blzs[t]));
      lat = 0; busy_ok = 1'b1;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
        @(negedge clk);
        load = 1'b0;
        if (done === 1'b1) lat = k;
        else if (busy !== 1'b1) busy_ok = 1'b0;
      end
      n_checks++; if (lat != LATENCY) begin n_fail++; $display("FAIL latency[%0d]: got %0d expected %0d", vals[t], lat, LATENCY); end
      n_checks++; if (!busy_ok) begin n_fail++; $display("FAIL busy_during[%0d]: got 0 expected 1", vals[t]); end
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_checks++; if (dig_value !== x.dv) begin n_fail++; $display("FAIL value[%0d,blz=%0b]: got %h expected %h", vals[t], blzs[t], dig_value, x.dv); end
        n_checks++; if (dig_en !== x.en) begin n_fail++; $display("FAIL en[%0d,blz=%0b]: got %b expected %b", vals[t], blzs[t], dig_en, x.en); end
        n_checks++; if (ovf !== x.ovf) begin n_fail++; $display("FAIL ovf[%0d]: got %b expected %b", vals[t], ovf, x.ovf); end
      end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done[%0d]: got %b expected 0", vals[t], busy); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse[%0d]: got %b expected 0", vals[t], done); end
      n_checks++; if (dig_value !== model(vals[t], blzs[t]).dv) begin n_fail++; $display("FAIL hold[%0d]: got %h", vals[t], dig_value); end
    end
  endtask

  task automatic test_load_while_busy();
    int   dones = 0;
    bit   busy_ok = 1'b1;
    exp_t x;
    @(negedge clk);
    value = WIDTH'(1234); blank_lz = 1'b1; load = 1'b1;
    sb.push_back(model(1234, 1'b1));
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      load = (k >= 3 && k <= 10);
      value = WIDTH'(-7); blank_lz = 1'b0;
      if (k <= 12 && busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (sb.size() > 0) begin
          x = sb.pop_front();
          n_checks++; if (dig_value !== x.dv) begin n_fail++; $display("FAIL busy_load_value: got %h expected %h", dig_value, x.dv); end
        end
      end
    end
    load = 1'b0;
    n_checks++; if (!busy_ok) begin n_fail++; $display("FAIL busy_load_busy: got 0 expected 1"); end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL busy_load_dones: got %0d expected 1", dones); end
  endtask

  task automatic test_back_to_back();
    int   lat = 0;
    int   first = 0;
    exp_t x;
    @(negedge clk);
    value = WIDTH'(-42); blank_lz = 1'b1; load = 1'b1;
    sb.push_back(model(-42, 1'b1));
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (done === 1'b1) begin
        if (sb.size() > 0) begin
          x = sb.pop_front();
          n_checks++; if (dig_value !== x.dv) begin n_fail++; $display("FAIL b2b_value: got %h expected %h", dig_value, x.dv); end
          n_checks++; if (dig_en !== x.en) begin n_fail++; $display("FAIL b2b_en: got %b expected %b", dig_en, x.en); end
        end
        if (first == 0) begin
          first = k;
          value = WIDTH'(907); blank_lz = 1'b0; load = 1'b1;
          sb.push_back(model(907, 1'b0));
        end else lat = k - first;
      end
    end
    n_checks++; if (lat != LATENCY) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LATENCY); end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    @(negedge clk);
    value = WIDTH'(-1000); blank_lz = 1'b1; load = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      load = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (dig_en !== '0) begin n_fail++; $display("FAIL abort_en: got %b expected 0", dig_en); end
    n_checks++; if (dig_value !== {DIGITS{BCD_BLANK}}) begin n_fail++; $display("FAIL abort_value: got %h", dig_value); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL abort_ovf: got %b expected 0", ovf); end
    rst = 1'b1; load = 1'b1; value = WIDTH'(5);
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_wins_busy: got %b expected 0", busy); end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
  endtask

  initial begin
    test_reset();
    test_conversions();
    test_load_while_busy();
    test_back_to_back();
    test_reset_abort();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
